// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment capture path: segment patterns, code widths
// and the decoder result payload.
package seg7_pkg;

  // Polarity: segments are active-low (0 = lit); on the bus a is bit 7 ... g is bit 1, dp is bit 0.
  localparam int unsigned SEG_BUS_W = 8;
  localparam int unsigned SEG_W     = 7;
  localparam int unsigned CODE_W    = 4;

  localparam logic [SEG_W-1:0] SEG_PAT_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_PAT_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_PAT_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_PAT_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_PAT_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_PAT_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_PAT_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_PAT_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_PAT_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_PAT_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_PAT_BLANK = 7'b1111111;

  localparam logic [CODE_W-1:0] SEG_BLANK_CODE = 4'hF;

  // Decoder result: ok is low for any pattern that is neither a digit nor blank.
  typedef struct packed {
    logic              ok;
    logic [CODE_W-1:0] code;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_dec.sv
// Combinational decode of one a..g segment pattern back to its BCD code.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output seg7_dec_t        dec_c
);

  always_comb begin
    dec_c.ok   = 1'b1;
    dec_c.code = SEG_BLANK_CODE;
    case (seg_i)
      SEG_PAT_0:     dec_c.code = 4'd0;
      SEG_PAT_1:     dec_c.code = 4'd1;
      SEG_PAT_2:     dec_c.code = 4'd2;
      SEG_PAT_3:     dec_c.code = 4'd3;
      SEG_PAT_4:     dec_c.code = 4'd4;
      SEG_PAT_5:     dec_c.code = 4'd5;
      SEG_PAT_6:     dec_c.code = 4'd6;
      SEG_PAT_7:     dec_c.code = 4'd7;
      SEG_PAT_8:     dec_c.code = 4'd8;
      SEG_PAT_9:     dec_c.code = 4'd9;
      SEG_PAT_BLANK: dec_c.code = SEG_BLANK_CODE;
      default:       dec_c.ok   = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Samples a multiplexed active-low 7-segment bus and commits each digit's code
// once it has been seen identically on STABLE consecutive samples of that digit.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned STABLE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEG_BUS_W-1:0]     seg_in,
  input  logic [DIGITS-1:0]        an_in,
  input  logic                     sample,
  output logic [CODE_W*DIGITS-1:0] digits_o,
  output logic [DIGITS-1:0]        dig_valid_o,
  output logic                     upd_o,
  output logic                     err_o
);

  localparam int unsigned CNT_W = $clog2(STABLE + 1);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DIGITS-1:0][CODE_W-1:0] cand_q, cand_d;
  logic [DIGITS-1:0][CODE_W-1:0] digits_q, digits_d;
  logic [DIGITS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIGITS-1:0]             cvld_q, cvld_d;
  logic [DIGITS-1:0]             dvld_q, dvld_d;
  logic                          upd_q, upd_d;
  logic                          err_q, err_d;

  logic [DIGITS-1:0] an_low;
  logic              any_low;
  logic              multi_low;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt_new;
  seg7_dec_t         dec;
  logic              dp_unused;

  assign dp_unused = seg_in[0];

  seg7_dec u_dec (
    .seg_i (seg_in[SEG_BUS_W-1:1]),
    .dec_c (dec)
  );

  // Anode decode: clearing the lowest set bit leaves something only if 2+ are low.
  always_comb begin
    an_low    = ~an_in;
    any_low   = |an_low;
    multi_low = |(an_low & (an_low - DIGITS'(1)));
    idx       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_low[i]) idx = IDX_W'(i);
    end
  end

  // Per-digit stability filter and commit.
  always_comb begin
    cand_d   = cand_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    cvld_d   = cvld_q;
    dvld_d   = dvld_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;
    cnt_new  = CNT_ONE;

    if (sample && any_low && !multi_low) begin
      if (dec.ok) begin
        if (cvld_q[idx] && (dec.code == cand_q[idx])) begin
          cnt_new = (cnt_q[idx] == CNT_MAX) ? CNT_MAX : cnt_q[idx] + CNT_ONE;
        end
        cand_d[idx] = dec.code;
        cvld_d[idx] = 1'b1;
        cnt_d[idx]  = cnt_new;
        if ((cnt_new == CNT_MAX) &&
            ((dec.code != digits_q[idx]) || !dvld_q[idx])) begin
          digits_d[idx] = dec.code;
          dvld_d[idx]   = 1'b1;
          upd_d         = 1'b1;
        end
      end else begin
        err_d       = 1'b1;
        cvld_d[idx] = 1'b0;
        cnt_d[idx]  = '0;
      end
    end else if (sample && multi_low) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= {DIGITS{SEG_BLANK_CODE}};
      digits_q <= {DIGITS{SEG_BLANK_CODE}};
      cnt_q    <= '0;
      cvld_q   <= '0;
      dvld_q   <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      cvld_q   <= cvld_d;
      dvld_q   <= dvld_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  assign digits_o    = digits_q;
  assign dig_valid_o = dvld_q;
  assign upd_o       = upd_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized self-checking bench for seg7_capture; the reference keeps a short
// history of recent codes per digit and commits when the last STABLE agree.
module tb_seg7_capture;

  localparam int DIGITS = 8;
  localparam int STABLE = 2;

  logic                  clk;
  logic                  rst_n;
  logic [7:0]            seg_in;
  logic [DIGITS-1:0]     an_in;
  logic                  sample;
  logic [4*DIGITS-1:0]   digits_o;
  logic [DIGITS-1:0]     dig_valid_o;
  logic                  upd_o;
  logic                  err_o;

  seg7_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .sample      (sample),
    .digits_o    (digits_o),
    .dig_valid_o (dig_valid_o),
    .upd_o       (upd_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] pat_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  // Reference state: recent code history per digit plus what the panel shows.
  int hist [DIGITS][$];
  int m_dig [DIGITS];
  bit m_dv  [DIGITS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mkseg(input int v);
    logic [6:0] p;
    p = pat_tab[v];
    return {p, 1'b0};
  endfunction

  function automatic int ref_decode(input logic [6:0] p);
    for (int v = 0; v < 10; v++) if (p == pat_tab[v]) return v;
    if (p == 7'h7F) return 15;
    return -1;
  endfunction

  function automatic logic [31:0] exp_digits();
    logic [31:0] e;
    int          c;
    for (int i = 0; i < DIGITS; i++) begin
      c = m_dig[i];
      e[4*i +: 4] = c[3:0];
    end
    return e;
  endfunction

  function automatic logic [7:0] exp_valid();
    logic [7:0] e;
    for (int i = 0; i < DIGITS; i++) e[i] = m_dv[i];
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) begin
      hist[i].delete();
      m_dig[i] = 15;
      m_dv[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input logic [7:0] seg, input logic [7:0] an, input logic smp,
                            output bit eu, output bit ee);
    int  lows, ix, d;
    bit  same;
    eu = 1'b0;
    ee = 1'b0;
    ix = 0;
    if (!smp) return;
    lows = $countones(~an);
    if (lows > 1) begin ee = 1'b1; return; end
    if (lows == 0) return;
    for (int k = 0; k < DIGITS; k++) if (!an[k]) ix = k;
    d = ref_decode(seg[7:1]);
    if (d < 0) begin
      ee = 1'b1;
      hist[ix].delete();
      return;
    end
    hist[ix].push_back(d);
    if (hist[ix].size() > STABLE) void'(hist[ix].pop_front());
    same = (hist[ix].size() == STABLE);
    foreach (hist[ix][j]) if (hist[ix][j] != d) same = 1'b0;
    if (same && (d != m_dig[ix] || !m_dv[ix])) begin
      m_dig[ix] = d;
      m_dv[ix]  = 1'b1;
      eu        = 1'b1;
    end
  endtask

  // One clock of stimulus; outputs are compared 1 time unit after the edge.
  task automatic drive(input logic [7:0] seg, input logic [7:0] an, input logic smp);
    bit eu, ee;
    @(negedge clk);
    rst_n  = 1'b1;
    seg_in = seg;
    an_in  = an;
    sample = smp;
    @(posedge clk);
    #1;
    model_step(seg, an, smp, eu, ee);
    check_eq("digits", digits_o, exp_digits());
    check_eq("valid", 32'(dig_valid_o), 32'(exp_valid()));
    check_eq("upd", 32'(upd_o), 32'(eu));
    check_eq("err", 32'(err_o), 32'(ee));
  endtask

  logic [7:0] r_seg, r_an;
  logic       r_smp;
  int         k, r, v, j;

  initial begin
    seg_in = 8'hFF;
    an_in  = 8'hFF;
    sample = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_digits", digits_o, 32'hFFFFFFFF);
    check_eq("rst_valid", 32'(dig_valid_o), 32'h0);
    check_eq("rst_upd", 32'(upd_o), 32'h0);
    check_eq("rst_err", 32'(err_o), 32'h0);
    repeat (3) drive(8'hFF, 8'hFF, 1'b0);

    // Digit 3 shows "2" twice.
    drive(mkseg(2) | 8'h01, ~8'h08, 1'b1);
    check_eq("d3_no_commit_yet", 32'(dig_valid_o[3]), 32'h0);
    drive(mkseg(2), ~8'h08, 1'b1);
    check_eq("d3_code", 32'(digits_o[15:12]), 32'h2);
    check_eq("d3_upd", 32'(upd_o), 32'h1);
    drive(8'hFF, 8'hFF, 1'b0);

    // Digit 0: 5, 6, 5, 5 -> only the last commits.
    drive(mkseg(5), ~8'h01, 1'b1);
    drive(mkseg(6), ~8'h01, 1'b1);
    check_eq("d0_no_six", 32'(digits_o[3:0]), 32'hF);
    drive(mkseg(5), ~8'h01, 1'b1);
    check_eq("d0_still_blank", 32'(digits_o[3:0]), 32'hF);
    drive(mkseg(5), ~8'h01, 1'b1);
    check_eq("d0_five", 32'(digits_o[3:0]), 32'h5);

    // Illegal pattern on digit 1, then a single valid sample must not commit.
    drive(8'b11100001, ~8'h02, 1'b1);
    check_eq("d1_err", 32'(err_o), 32'h1);
    drive(mkseg(7), ~8'h02, 1'b1);
    check_eq("d1_restart", 32'(dig_valid_o[1]), 32'h0);
    drive(mkseg(7), ~8'h02, 1'b1);
    check_eq("d1_seven", 32'(digits_o[7:4]), 32'h7);

    // Two anodes low, then none low.
    drive(mkseg(8), 8'b11110011, 1'b1);
    check_eq("multi_err", 32'(err_o), 32'h1);
    drive(mkseg(8), 8'hFF, 1'b1);
    check_eq("none_err", 32'(err_o), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 7));
      r = int'($urandom_range(0, 19));
      r_an = ~(8'h01 << k);
      if (r == 0) r_an = 8'hFF;
      else if (r == 1) begin
        j = int'($urandom_range(0, 6));
        r_an[(k + 1 + j) % 8] = 1'b0;
      end
      r = int'($urandom_range(0, 19));
      if (r < 12) v = (k + n / 50) % 10;
      else if (r < 17) v = int'($urandom_range(0, 9));
      else v = -1;
      if (v >= 0) r_seg = mkseg(v) | 8'(r & 1);
      else if (r == 17) r_seg = 8'hFF;
      else r_seg = 8'($urandom);
      r_smp = ($urandom_range(0, 4) != 0);
      drive(r_seg, r_an, r_smp);
    end

    // Two full back-to-back scans of "01234567".
    for (int rep = 0; rep < 2; rep++)
      for (int d = 0; d < DIGITS; d++) drive(mkseg(d), ~(8'h01 << d), 1'b1);
    check_eq("scan_digits", digits_o, 32'h76543210);
    check_eq("scan_valid", 32'(dig_valid_o), 32'hFF);

    // Reset mid third scan, released together with a sample.
    for (int d = 0; d < 3; d++) drive(mkseg(d), ~(8'h01 << d), 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_digits", digits_o, 32'hFFFFFFFF);
    check_eq("async_valid", 32'(dig_valid_o), 32'h0);
    check_eq("async_upd", 32'(upd_o), 32'h0);
    check_eq("async_err", 32'(err_o), 32'h0);
    drive(mkseg(9), ~8'h04, 1'b1);
    check_eq("post_rst_one", 32'(dig_valid_o), 32'h0);
    drive(mkseg(9), ~8'h04, 1'b1);
    check_eq("post_rst_commit", digits_o, 32'hFFFFF9FF);
    drive(8'hFF, 8'hFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side counterpart of the display encoder. It samples a time-multiplexed, active-low 7-segment bus (segment lines plus digit anodes) and decodes each digit's pattern back to a 4-bit BCD code. A per-digit stability filter holds each code until it has been stable for several scan frames. The block sits between the display pins and the self-check/readback logic, so firmware and benches can read what the panel actually shows.

## Interface
- `DIGITS`, default 8: number of multiplexed digits.
- `STABLE`, default 2: consecutive identical samples of one digit required before commit; legal range ≥1.
- `clk`  in  1: the single clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `seg_in`  in  8: active-low segments, bit7=a … bit1=g, bit0=dp.
- `an_in`  in  DIGITS: active-low digit enables; legal sample when exactly one bit is low.
- `sample`  in  1: strobe; seg_in/an_in are captured only in cycles where it is high.
- `digits_o`  out  4*DIGITS: committed codes; digit i occupies [4i+3:4i].
- `dig_valid_o`  out  DIGITS: digit i has committed at least once since reset.
- `upd_o`  out  1: one-cycle pulse when any digit's committed code changes.
- `err_o`  out  1: one-cycle pulse on an illegal sample.

## Operation
- Decode uses seg_in[7:1] only. dp is ignored.
- Codes for 0–9, given as a..g with 0 meaning lit:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
- 1111111 is blank and decodes to code 4'hF. Any other pattern is invalid.
- Per-digit state: candidate code `cand[i]`, valid flag `cvld[i]`, saturating counter `cnt[i]` of width $clog2(STABLE+1).
- A sample is processed when `sample`=1 and exactly one an_in bit is low (index i).
- Processing a decoded code d for digit i:
  - If cvld[i] and d==cand[i]: cnt[i] increments, saturating at STABLE.
  - Otherwise: cand[i]=d, cvld[i]=1, cnt[i]=1.
  - When the new cnt[i] equals STABLE and d differs from digits_o[i], or dig_valid_o[i]=0: commit. digits_o[i]=d and dig_valid_o[i]=1.
  - upd_o pulses only if the code value changed. A first-time commit of a code equal to the current output still sets dig_valid_o[i] and pulses upd_o.
- Invalid pattern on digit i: err_o pulses, cvld[i]=0, cnt[i]=0. Committed state is unchanged.
- Multiple an_in bits low: err_o pulses and the sample is ignored; no state changes.
- No an_in bit low, or `sample`=0: no action and no pulse.
- With STABLE=1, every valid sample commits immediately.

## Timing
- All outputs are registered.
- A commit triggered by the sample in cycle N is visible on digits_o, dig_valid_o and upd_o in cycle N+1.
- err_o for the sample in cycle N is high in cycle N+1 only.
- Back-to-back `sample` every cycle is supported, with full throughput and no stalls.
- Samples of different digits are independent. Interleaved scanning does not reset another digit's counter.
- Reset values, applied asynchronously while rst_n=0:
  - digits_o = all 4'hF; dig_valid_o = 0; upd_o = 0; err_o = 0.
  - cand = 4'hF; cvld = 0; cnt = 0.
- Reset released mid-scan: the next legal sample starts at cnt=1, and no partial history is retained.
- `sample` coincident with reset deassertion is processed normally on the first clock edge after rst_n rises.

## Structure
- Package `seg7_pkg`:
  - localparams for the ten segment patterns and the blank pattern;
  - the `SEG_BLANK_CODE` constant (4'hF);
  - the polarity note (active-low, bit7=a).
- Sub-module `seg7_dec` is combinational: seg[7:1] → {ok, code[3:0]}. It is instantiated once, since only one digit is sampled per cycle.
- Top level `seg7_capture` contains the one-hot check, the per-digit state arrays, and commit/pulse generation.

## Test plan
- Reset, then idle: digits_o = 0xFFFFFFFF, dig_valid_o = 0x00, no pulses.
- STABLE=2: digit 3 gets pattern 0010010 (a..g) on two samples → digits_o[15:12] = 2, dig_valid_o[3] = 1, upd_o high for one cycle after the second sample.
- Digit 0 samples the sequence 5, 6, 5, 5 → only the final sample commits 5; there is no intermediate commit of 6.
- Illegal patterns:
  - seg_in[7:1] = 1110000 on digit 1 → err_o pulse, digits_o unchanged.
  - The next single sample of a valid code restarts the count and does not commit while STABLE=2.
- an_in = 8'b11110011 (two digits low) with `sample` → err_o pulse and no state change. an_in = 8'hFF with `sample` → nothing.
- Full 8-digit scan of "01234567", repeated twice and sampled every cycle:
  - digits_o = 0x76543210 and all dig_valid_o set.
  - Assert rst_n=0 mid-third-scan → outputs return to reset values asynchronously.
